// File: rtl/uart_resp_tx_pkg.sv
// Shared definitions for the host command link: framing constants,
// byte-slot and bit-state enums, and the CRC8 step used on both directions.
package uart_resp_tx_pkg;

    localparam logic [7:0] SOF      = 8'hAA;
    localparam logic [7:0] CRC_POLY = 8'h07;

    // Which byte of the response frame is currently on the wire
    typedef enum logic [2:0] {
        SLOT_SOF,
        SLOT_LEN,
        SLOT_CMD,
        SLOT_PAY,
        SLOT_CRC
    } slot_e;

    // Bit-level state of the UART byte serializer
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    // One byte of CRC8 (poly 0x07, MSB first, no reflection, no final XOR)
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer: bit timer plus shift register, LSB first.
// A new byte may be loaded while idle or in the last cycle of the stop bit,
// so consecutive bytes follow each other with no idle gap.
module uart_tx_byte
    import uart_resp_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 32
)(
    input  logic       CLK,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       done,
    output logic       TX
);

    localparam int             CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;

    assign done = (state_q == ST_STOP) && (cnt_q == LAST);
    assign TX   = tx_q;

    // Bit sequencing: start bit, eight data bits, stop bit; TX held registered
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else if (load && ((state_q == ST_IDLE) || done)) begin
            state_q <= ST_START;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= byte_in;
            tx_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                end
                ST_START: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= ST_DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_resp_tx.sv
// Response-frame transmitter: SOF, LEN, CMD, payload, CRC8 sent as UART 8N1.
// Owns frame sequencing, the length clamp, the running CRC and the frame counter;
// the byte serializer owns the line itself.
module uart_resp_tx
    import uart_resp_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 32,
    parameter int MAX_PAYLOAD  = 8
)(
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     resp_valid,
    output logic                     resp_ready,
    input  logic [7:0]               resp_cmd,
    input  logic [3:0]               resp_len,
    input  logic [8*MAX_PAYLOAD-1:0] resp_payload,
    output logic                     TX,
    output logic                     busy,
    output logic [15:0]              frames_sent
);

    localparam logic [3:0] MAX_LEN = 4'(MAX_PAYLOAD);

    slot_e                    slot_q;
    slot_e                    slot_d;
    logic                     ready_q;
    logic                     busy_q;
    logic [7:0]               cmd_q;
    logic [3:0]               len_q;
    logic [3:0]               rem_q;
    logic [8*MAX_PAYLOAD-1:0] pay_q;
    logic [7:0]               crc_q;
    logic [15:0]              frames_q;

    logic       accept;
    logic [3:0] lenClamped;
    logic [7:0] lenByte;
    logic       byteDone;
    logic       txLoad;
    logic [7:0] txByte;
    logic       crcEn;
    logic       frameEnd;

    assign accept      = resp_valid && ready_q;
    assign lenClamped  = (resp_len > MAX_LEN) ? MAX_LEN : resp_len;
    assign lenByte     = {4'd0, len_q} + 8'd2;
    assign resp_ready  = ready_q;
    assign busy        = busy_q;
    assign frames_sent = frames_q;

    // Pick the next byte for the serializer and whether it feeds the CRC;
    // the SOF goes out on the accept edge, later bytes on each byte-done edge
    always_comb begin
        txLoad   = 1'b0;
        txByte   = SOF;
        crcEn    = 1'b0;
        frameEnd = 1'b0;
        slot_d   = slot_q;
        if (accept) begin
            txLoad = 1'b1;
            txByte = SOF;
            slot_d = SLOT_SOF;
        end else if (busy_q && byteDone) begin
            case (slot_q)
                SLOT_SOF: begin
                    txLoad = 1'b1;
                    txByte = lenByte;
                    crcEn  = 1'b1;
                    slot_d = SLOT_LEN;
                end
                SLOT_LEN: begin
                    txLoad = 1'b1;
                    txByte = cmd_q;
                    crcEn  = 1'b1;
                    slot_d = SLOT_CMD;
                end
                SLOT_CMD, SLOT_PAY: begin
                    txLoad = 1'b1;
                    if (rem_q == 4'd0) begin
                        txByte = crc_q;
                        slot_d = SLOT_CRC;
                    end else begin
                        txByte = pay_q[7:0];
                        crcEn  = 1'b1;
                        slot_d = SLOT_PAY;
                    end
                end
                SLOT_CRC: begin
                    frameEnd = 1'b1;
                    slot_d   = SLOT_SOF;
                end
                default: begin
                    slot_d = SLOT_SOF;
                end
            endcase
        end
    end

    // Frame state: latch the request, track slot, CRC and remaining payload, count frames
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            slot_q   <= SLOT_SOF;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            cmd_q    <= '0;
            len_q    <= '0;
            rem_q    <= '0;
            pay_q    <= '0;
            crc_q    <= '0;
            frames_q <= '0;
        end else begin
            slot_q <= slot_d;
            if (accept) begin
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
                cmd_q   <= resp_cmd;
                len_q   <= lenClamped;
                rem_q   <= lenClamped;
                pay_q   <= resp_payload;
                crc_q   <= 8'h00;
            end
            if (crcEn) begin
                crc_q <= crc8_step(crc_q, txByte);
            end
            if (txLoad && (slot_d == SLOT_PAY)) begin
                pay_q <= pay_q >> 8;
                rem_q <= rem_q - 1'b1;
            end
            if (frameEnd) begin
                ready_q  <= 1'b1;
                busy_q   <= 1'b0;
                frames_q <= frames_q + 1'b1;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .CLK    (CLK),
        .rst    (rst),
        .load   (txLoad),
        .byte_in(txByte),
        .done   (byteDone),
        .TX     (TX)
    );

endmodule

// File: tb/tb_uart_resp_tx.sv
// Testbench for uart_resp_tx: a line sniffer decodes TX into bytes and each
// frame is compared with literal frames or a frame-level reference model.
module tb_uart_resp_tx;

    localparam int CLKS     = 32;
    localparam int MAXP     = 8;
    localparam int BYTE_CYC = 10 * CLKS;

    typedef logic [7:0] byteQ_t[$];

    logic              CLK = 1'b0;
    logic              rst = 1'b0;
    logic              resp_valid = 1'b0;
    logic              resp_ready;
    logic [7:0]        resp_cmd = 8'h00;
    logic [3:0]        resp_len = 4'h0;
    logic [8*MAXP-1:0] resp_payload = '0;
    logic              TX;
    logic              busy;
    logic [15:0]       frames_sent;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int stopErrs  = 0;
    int tFall     = 0;
    int tEnd      = 0;
    int expFrames = 0;

    logic [7:0] rxQ[$];

    uart_resp_tx #(
        .CLKS_PER_BIT(CLKS),
        .MAX_PAYLOAD (MAXP)
    ) dut (
        .CLK         (CLK),
        .rst         (rst),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_cmd    (resp_cmd),
        .resp_len    (resp_len),
        .resp_payload(resp_payload),
        .TX          (TX),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    // Free-running clock
    always #5 CLK = ~CLK;

    // Cycle counter used for timing measurements
    always @(posedge CLK) cyc <= cyc + 1;

    // Line sniffer: detect a start bit, sample each bit at its middle, push the byte
    initial begin
        logic [7:0] rxByte;
        forever begin
            @(negedge CLK);
            if (rst === 1'b1 && TX === 1'b0) begin
                repeat (CLKS / 2) @(negedge CLK);
                for (int b = 0; b < 8; b++) begin
                    repeat (CLKS) @(negedge CLK);
                    rxByte[b] = TX;
                end
                repeat (CLKS) @(negedge CLK);
                if (TX !== 1'b1) stopErrs++;
                rxQ.push_back(rxByte);
            end
        end
    end

    // Reference frame: clamp, header, payload, then CRC8 as polynomial long division
    function automatic byteQ_t modelFrame(input logic [7:0] cmd, input int len,
                                          input logic [8*MAXP-1:0] pay);
        byteQ_t     f;
        int         n;
        logic [7:0] crc;
        logic [7:0] cur;
        logic       fb;
        n = (len > MAXP) ? MAXP : len;
        f.push_back(8'hAA);
        f.push_back(8'(n + 2));
        f.push_back(cmd);
        for (int i = 0; i < n; i++) f.push_back(pay[8*i +: 8]);
        crc = 8'h00;
        for (int k = 1; k < f.size(); k++) begin
            cur = f[k];
            for (int b = 7; b >= 0; b--) begin
                fb  = crc[7] ^ cur[b];
                crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        f.push_back(crc);
        return f;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request; the block is idle so it is taken on the next edge
    task automatic applyStimulus(input logic [7:0] cmd, input logic [3:0] len,
                                 input logic [8*MAXP-1:0] pay, input bit hold);
        @(negedge CLK);
        resp_cmd     = cmd;
        resp_len     = len;
        resp_payload = pay;
        resp_valid   = 1'b1;
        @(negedge CLK);
        if (!hold) resp_valid = 1'b0;
        tFall = cyc;
        checkVal("accept_ready", {31'd0, resp_ready}, 32'd0);
        checkVal("accept_tx",    {31'd0, TX},         32'd0);
        checkVal("accept_busy",  {31'd0, busy},       32'd1);
    endtask

    // Wait for end of frame, then check duration, counter and every sniffed byte
    task automatic checkOutput(input string tag, input byteQ_t exp);
        int   budget;
        bit   seen;
        logic [31:0] obs;
        budget = (MAXP + 4) * BYTE_CYC + 100;
        seen   = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge CLK);
            if (resp_ready === 1'b1) seen = 1'b1;
        end
        checkVal({tag, "_end"}, {31'd0, seen}, 32'd1);
        tEnd = cyc;
        expFrames++;
        checkVal({tag, "_cycles"}, 32'(tEnd - tFall), 32'(exp.size() * BYTE_CYC));
        checkVal({tag, "_frames"}, {16'd0, frames_sent}, {16'd0, 16'(expFrames)});
        checkVal({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkVal({tag, "_nbytes"}, 32'(rxQ.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            obs = (i < rxQ.size()) ? {24'd0, rxQ[i]} : 32'hFFFF_FFFF;
            checkVal($sformatf("%s_b%0d", tag, i), obs, {24'd0, exp[i]});
        end
        rxQ.delete();
    endtask

    // Directed and randomized sequence
    initial begin
        byteQ_t            expA;
        byteQ_t            expB;
        logic [8*MAXP-1:0] payR;
        logic [7:0]        cmdR;
        int                lenR;

        repeat (3) @(negedge CLK);
        checkVal("rst_tx",     {31'd0, TX},         32'd1);
        checkVal("rst_ready",  {31'd0, resp_ready}, 32'd1);
        checkVal("rst_busy",   {31'd0, busy},       32'd0);
        checkVal("rst_frames", {16'd0, frames_sent}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge CLK);

        $display("[TB] zero-payload frame");
        applyStimulus(8'h01, 4'd0, '0, 1'b0);
        checkOutput("zero", '{8'hAA, 8'h02, 8'h01, 8'h2D});

        $display("[TB] single payload byte frames");
        applyStimulus(8'h02, 4'd1, 64'h00, 1'b0);
        checkOutput("p00", '{8'hAA, 8'h03, 8'h02, 8'h00, 8'h97});
        applyStimulus(8'h02, 4'd1, 64'hF0, 1'b0);
        checkOutput("pF0", '{8'hAA, 8'h03, 8'h02, 8'hF0, 8'h49});

        $display("[TB] status frame");
        applyStimulus(8'h07, 4'd4, 64'h0003_0001, 1'b0);
        checkOutput("status", modelFrame(8'h07, 4, 64'h0003_0001));

        $display("[TB] back-to-back frames with valid held");
        expA = modelFrame(8'h55, 2, 64'hBEEF);
        payR = {$urandom(), $urandom()};
        expB = modelFrame(8'h33, 3, payR);
        applyStimulus(8'h55, 4'd2, 64'hBEEF, 1'b1);
        resp_cmd     = 8'h33;
        resp_len     = 4'd3;
        resp_payload = payR;
        checkOutput("b2bA", expA);
        @(negedge CLK);
        checkVal("b2b_tx",  {31'd0, TX}, 32'd0);
        checkVal("b2b_gap", 32'(cyc - tEnd), 32'd1);
        tFall      = cyc;
        resp_valid = 1'b0;
        checkOutput("b2bB", expB);

        $display("[TB] length clamp");
        payR = {$urandom(), $urandom()};
        applyStimulus(8'h44, 4'd12, payR, 1'b0);
        checkOutput("clamp", modelFrame(8'h44, 12, payR));

        $display("[TB] randomized frames");
        for (int r = 0; r < 3; r++) begin
            cmdR = 8'($urandom());
            lenR = $urandom_range(0, MAXP);
            payR = {$urandom(), $urandom()};
            applyStimulus(cmdR, 4'(lenR), payR, 1'b0);
            checkOutput($sformatf("rand%0d", r), modelFrame(cmdR, lenR, payR));
        end

        $display("[TB] reset during payload");
        applyStimulus(8'h07, 4'd4, 64'h0003_0001, 1'b0);
        repeat (3 * BYTE_CYC + 50) @(negedge CLK);
        #1 rst = 1'b0;
        #1;
        checkVal("abort_tx",     {31'd0, TX},         32'd1);
        checkVal("abort_busy",   {31'd0, busy},       32'd0);
        checkVal("abort_ready",  {31'd0, resp_ready}, 32'd1);
        checkVal("abort_frames", {16'd0, frames_sent}, 32'd0);
        expFrames = 0;
        repeat (5) @(negedge CLK);
        rst = 1'b1;
        repeat (BYTE_CYC + 40) @(negedge CLK);
        rxQ.delete();
        applyStimulus(8'h01, 4'd0, '0, 1'b0);
        checkOutput("after_rst", '{8'hAA, 8'h02, 8'h01, 8'h2D});

        checkVal("stop_bits", 32'(stopErrs), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_resp_tx.md
# uart_resp_tx

Response-frame transmitter for the host command link: the FPGA→PC counterpart of the command receiver. It accepts one response (command byte plus up to MAX_PAYLOAD payload bytes) from the command engine and builds the frame SOF, LEN, CMD, payload, CRC8. It serializes the frame on TX as UART 8N1, LSB first, using the same framing and CRC rules the host uses toward the FPGA.

## Interface
- CLKS_PER_BIT, default 32: clock cycles per UART bit (100 MHz / 3.125 Mbaud).
- MAX_PAYLOAD, default 8: maximum payload bytes per response.
- CLK  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- resp_valid  input  1  response request.
- resp_ready  output  1  block can accept a request.
- resp_cmd  input  8  CMD byte to echo or report.
- resp_len  input  4  payload byte count, 0..MAX_PAYLOAD.
- resp_payload  input  8*MAX_PAYLOAD  payload; byte i is bits [8i+7:8i], P0 sent first.
- TX  output  1  UART line; idles high.
- busy  output  1  frame in progress.
- frames_sent  output  16  count of completed frames; wraps.

## Operation
- States: IDLE, START, DATA, STOP. The byte index selects SOF / LEN / CMD / P[i] / CRC.
- IDLE: resp_ready=1, TX=1, busy=0. On resp_valid&&resp_ready the block latches cmd, len and payload, then enters START.
- Length clamp: resp_len > MAX_PAYLOAD is clamped to MAX_PAYLOAD.
- Frame byte sequence: 0xAA; LEN = n+2 (counts CMD and CRC bytes); CMD; P0..P(n-1); CRC.
- CRC8:
  - polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - Covers LEN, CMD and the payload. SOF is excluded.
  - Computed on the fly as each byte is loaded, so the CRC byte is ready when its slot arrives.
- Each byte is sent as: START (TX=0, one bit time), DATA (8 bits, LSB first), STOP (TX=1, one bit time).
- After the STOP of the CRC byte, frames_sent increments and the block returns to IDLE.
- Inputs are ignored while busy. Later changes to resp_* have no effect on the frame in flight.

## Timing
- Reset values: TX=1, resp_ready=1 (while in reset; the state is IDLE), busy=0, frames_sent=0, state=IDLE.
- Reset mid-frame: TX returns to 1 asynchronously and the frame is aborted. No partial CRC byte is sent.
- Accept cycle: resp_ready drops the cycle after acceptance. TX falls (SOF start bit) on the first clock edge after acceptance. TX is registered and glitch-free.
- Every bit lasts exactly CLKS_PER_BIT cycles. A byte takes 10*CLKS_PER_BIT cycles, with no idle gap between bytes of a frame.
- Frame duration: (n+4)*10*CLKS_PER_BIT cycles.
- End of frame: resp_ready reasserts the cycle after the final stop bit completes.
  - A request held valid is accepted then, giving back-to-back frames separated only by the stop bit.
- frames_sent increments in the same cycle resp_ready reasserts. It wraps 0xFFFF→0x0000.

## Structure
- Shared package holds:
  - SOF=8'hAA and CRC_POLY=8'h07;
  - the byte-slot enum (SOF, LEN, CMD, PAY, CRC) and the state enum;
  - the function crc8_step(crc, byte), shared with the command receiver.
- Sub-module uart_tx_byte: bit-timer plus shifter. Handshake load/byte_in/done; owns TX.
- The top level owns frame sequencing, the clamp, the CRC and the counter.

## Test plan
- Zero-payload response, cmd 0x01 → TX bytes AA 02 01 2D. Each bit is 32 clocks; frames_sent=1.
- cmd 0x02, len 1, P0=0x00 → AA 03 02 00 97. Then cmd 0x02, P0=0xF0 → AA 03 02 F0 49.
- Status-style response: cmd 0x07, len 4, payload 01 00 03 00.
  - Sniffer decodes AA 06 07 01 00 03 00 followed by the CRC8 computed by the bench model.
  - Duration is 8*320 cycles.
- resp_valid held high across two requests → second SOF start bit begins immediately after the first frame's stop bit; frames_sent=2.
- resp_len=12 with MAX_PAYLOAD=8 → LEN byte 0x0A, exactly 8 payload bytes sent.
- rst asserted during the payload byte → TX=1 immediately, busy=0, resp_ready=1, counter 0.
  - After release, a new cmd 0x01 request produces a clean AA 02 01 2D.
